cpsr_unit: RTL and testbench

- Architectural NZCV flag register for the CPU pipeline.
- Sits directly upstream of the condition checker: its flagsout drives the checker's CPSR input; the checker's pass bit returns here as ex_condpass.
- Captures flag writes from EX (ALU S-bit ops and MSR) into a one-entry pending slot, then commits them to the architectural register one cycle later.
- Forwards in-flight writes to the checker, or requests a stall when forwarding is compiled out.

---
 rtl/cpsr_unit_if.sv | 33 +++
 rtl/cpsr_unit.sv | 65 ++++++
 tb/tb_cpsr_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpsr_unit_if.sv
// EX-side flag-write bus and flag outputs of cpsr_unit.
// slave: the flag register; master: the pipeline driving it.
`ifndef FLAGS_W
`define FLAGS_W 4
`endif

interface cpsr_unit_if;
  logic                ex_valid;
  logic                ex_stall;
  logic                ex_flush;
  logic                ex_condpass;
  logic                ex_setflags;
  logic [`FLAGS_W-1:0] ex_flagmask;
  logic [`FLAGS_W-1:0] ex_aluflags;
  logic                ex_msr_we;
  logic [`FLAGS_W-1:0] ex_msr_data;
  logic                ex_usesflags;
  logic [`FLAGS_W-1:0] flagsout;
  logic [`FLAGS_W-1:0] cpsr_q;
  logic                flag_hazard;

  modport master (
    output ex_valid, ex_stall, ex_flush, ex_condpass, ex_setflags,
           ex_flagmask, ex_aluflags, ex_msr_we, ex_msr_data, ex_usesflags,
    input  flagsout, cpsr_q, flag_hazard
  );

  modport slave (
    input  ex_valid, ex_stall, ex_flush, ex_condpass, ex_setflags,
           ex_flagmask, ex_aluflags, ex_msr_we, ex_msr_data, ex_usesflags,
    output flagsout, cpsr_q, flag_hazard
  );
endinterface

// File: rtl/cpsr_unit.sv
// Architectural NZCV register with a one-entry pending write slot.
// CPSR_FWD_EN: forward the pending write to flagsout instead of requesting a stall.
`ifndef FLAGS_W
`define FLAGS_W 4
`endif

module cpsr_unit #(
  parameter logic [`FLAGS_W-1:0] RESET_FLAGS = 4'b0000
) (
  input logic         clk,
  input logic         reset,
  cpsr_unit_if.slave  bus
);

  logic                cap;
  logic [`FLAGS_W-1:0] cap_mask;
  logic [`FLAGS_W-1:0] cap_data;
  logic                pend_valid;
  logic [`FLAGS_W-1:0] pend_mask;
  logic [`FLAGS_W-1:0] pend_flags;
  logic [`FLAGS_W-1:0] cpsr;
  logic [`FLAGS_W-1:0] merged;

  always_comb begin
    cap = bus.ex_valid & ~bus.ex_stall & ~bus.ex_flush & bus.ex_condpass &
          (bus.ex_setflags | bus.ex_msr_we);
    // MSR writes every flag and takes priority over the ALU S-bit path
    if (bus.ex_msr_we) begin
      cap_mask = '1;
      cap_data = bus.ex_msr_data;
    end else begin
      cap_mask = bus.ex_flagmask;
      cap_data = bus.ex_aluflags;
    end
    merged = (cpsr & ~pend_mask) | (pend_flags & pend_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpsr       <= RESET_FLAGS;
      pend_valid <= 1'b0;
      pend_mask  <= '0;
      pend_flags <= '0;
    end else begin
      if (pend_valid)
        cpsr <= merged;
      pend_valid <= cap;
      if (cap) begin
        pend_mask  <= cap_mask;
        pend_flags <= cap_data;
      end
    end
  end

  assign bus.cpsr_q = cpsr;

`ifdef CPSR_FWD_EN
  assign bus.flagsout    = pend_valid ? merged : cpsr;
  assign bus.flag_hazard = 1'b0;
`else
  assign bus.flagsout    = cpsr;
  assign bus.flag_hazard = pend_valid & bus.ex_usesflags;
`endif

endmodule

// File: tb/tb_cpsr_unit.sv
// Scoreboard bench for cpsr_unit: a flag model pushes expected post-edge
// outputs at drive time; a monitor pops and compares after each rising edge.
`ifndef FLAGS_W
`define FLAGS_W 4
`endif

module tb_cpsr_unit;

  typedef struct packed {
    logic [3:0] cpsr;
    logic [3:0] flagsout;
    logic       hazard;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t sb[$];

  logic [3:0] m_cpsr;
  logic       m_pv;
  logic [3:0] m_pmask;
  logic [3:0] m_pflags;

  cpsr_unit_if bus ();

  cpsr_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("cpsr_q", bus.cpsr_q, e.cpsr);
      check("flagsout", bus.flagsout, e.flagsout);
      check("flag_hazard", {3'b000, bus.flag_hazard}, {3'b000, e.hazard});
    end
  end

  task automatic cyc(input logic rst, input logic v, input logic st, input logic fl,
                     input logic cp, input logic sf, input logic [3:0] m,
                     input logic [3:0] a, input logic msr, input logic [3:0] md,
                     input logic uf);
    logic       cap;
    logic [3:0] cmask, cdata, n_cpsr, n_pmask, n_pflags;
    logic       n_pv;
    exp_t       e;
    @(negedge clk);
    reset = rst;
    bus.ex_valid = v; bus.ex_stall = st; bus.ex_flush = fl; bus.ex_condpass = cp;
    bus.ex_setflags = sf; bus.ex_flagmask = m; bus.ex_aluflags = a;
    bus.ex_msr_we = msr; bus.ex_msr_data = md; bus.ex_usesflags = uf;
    cap   = v && !st && !fl && cp && (sf || msr);
    cmask = msr ? 4'b1111 : m;
    cdata = msr ? md : a;
    if (rst) begin
      n_cpsr = 4'b0000; n_pv = 1'b0; n_pmask = 4'b0000; n_pflags = 4'b0000;
    end else begin
      n_cpsr = m_cpsr;
      for (int unsigned i = 0; i < 4; i++)
        if (m_pv && m_pmask[i]) n_cpsr[i] = m_pflags[i];
      n_pv     = cap;
      n_pmask  = cap ? cmask : m_pmask;
      n_pflags = cap ? cdata : m_pflags;
    end
    m_cpsr = n_cpsr; m_pv = n_pv; m_pmask = n_pmask; m_pflags = n_pflags;
    e.cpsr = n_cpsr;
`ifdef CPSR_FWD_EN
    e.flagsout = n_cpsr;
    for (int unsigned i = 0; i < 4; i++)
      if (n_pv && n_pmask[i]) e.flagsout[i] = n_pflags[i];
    e.hazard = 1'b0;
`else
    e.flagsout = n_cpsr;
    e.hazard   = n_pv && uf;
`endif
    sb.push_back(e);
  endtask

  task automatic idle(input logic uf);
    cyc(0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0, 4'h0, uf);
  endtask

  task automatic alu(input logic [3:0] m, input logic [3:0] a);
    cyc(0, 1, 0, 0, 1, 1, m, a, 0, 4'h0, 0);
  endtask

  task automatic msr(input logic [3:0] d);
    cyc(0, 1, 0, 0, 1, 0, 4'h0, 4'h0, 1, d, 0);
  endtask

  initial begin
    m_cpsr = 4'b0000; m_pv = 1'b0; m_pmask = 4'b0000; m_pflags = 4'b0000;
    reset = 1'b1;
    bus.ex_valid = 0; bus.ex_stall = 0; bus.ex_flush = 0; bus.ex_condpass = 0;
    bus.ex_setflags = 0; bus.ex_flagmask = 0; bus.ex_aluflags = 0;
    bus.ex_msr_we = 0; bus.ex_msr_data = 0; bus.ex_usesflags = 0;

    // Reset with a capture-eligible instruction on the bus
    cyc(1, 1, 0, 0, 1, 1, 4'hF, 4'hA, 1, 4'hF, 1);
    cyc(1, 1, 0, 0, 1, 1, 4'hF, 4'hA, 0, 4'h0, 1);
    idle(0);

    // ADDS full mask
    alu(4'b1111, 4'b0110);
    idle(0);
    idle(0);

    // Partial mask keeps V
    msr(4'b1001);
    idle(0);
    alu(4'b1110, 4'b0100);
    idle(0);
    idle(0);

    // MSR beats S-bit; failed condition suppresses
    cyc(0, 1, 0, 0, 1, 1, 4'hF, 4'b0000, 1, 4'b1111, 0);
    idle(0);
    cyc(0, 1, 0, 0, 0, 1, 4'hF, 4'b0000, 1, 4'b0000, 0);
    idle(0);
    idle(0);

    // Pending entry commits across a flushed successor
    msr(4'b0011);
    cyc(0, 1, 0, 1, 1, 0, 4'h0, 4'h0, 1, 4'b1100, 0);
    idle(0);
    idle(0);

    // Stall held for three cycles, then one capture
    for (int unsigned i = 0; i < 3; i++)
      cyc(0, 1, 1, 0, 1, 1, 4'b1111, 4'b1010, 0, 4'h0, 0);
    alu(4'b1111, 4'b1010);
    idle(0);
    idle(0);

    // Hazard window after a capture
    alu(4'b1111, 4'b0101);
    idle(1);
    idle(1);

    // Back-to-back captures, empty mask, then random traffic
    alu(4'b1000, 4'b1111);
    alu(4'b0001, 4'b0000);
    alu(4'b0000, 4'b1111);
    msr(4'b0110);
    idle(1);
    idle(0);
    for (int unsigned i = 0; i < 40; i++)
      cyc(($urandom_range(0, 19) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
          4'($urandom_range(0, 15)), $urandom_range(0, 1));
    idle(0);
    idle(0);

    for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
